// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and stall patterns for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MC_RUN  = 2'd1;
  localparam logic [1:0] ST_MC_DONE = 2'd2;

  // Stall vector layout {wb,mem,ex,id,if,pc}, bit0 = pc.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  function automatic logic [5:0] single_cycle_stall(input logic req_id, input logic req_ex);
    logic [5:0] pat;
    if (req_ex) begin
      pat = STALL_EX;
    end else if (req_id) begin
      pat = STALL_ID;
    end else begin
      pat = STALL_NONE;
    end
    return pat;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: single-cycle hazard stalls, multi-cycle EX ops
// (div/madd) with cancel, pipeline flush, and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               mc_start,
  input  logic [CNT_W-1:0]   mc_cycles,
  input  logic               mc_cancel,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               mc_busy,
  output logic               mc_done,
  output logic [31:0]        stall_cnt
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] load_s;
  logic [5:0]       stall_s;
  logic             flush_s;
  logic             busy_s;
  logic             done_s;

  // Next-state, counter and unguarded output decode; flush wins over cancel, cancel over start.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    stall_s = single_cycle_stall(stallreq_id, stallreq_ex);
    flush_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    // A zero length is treated as a one-cycle op.
    if (mc_cycles == {CNT_W{1'b0}}) begin
      load_s = {CNT_W{1'b0}};
    end else begin
      load_s = mc_cycles - CNT_W'(1);
    end

    if (flush_req) begin
      flush_s = 1'b1;
      stall_s = STALL_NONE;
      busy_s  = (state_q == ST_MC_RUN);
      state_d = ST_IDLE;
      count_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mc_start && !mc_cancel) begin
            stall_s = STALL_EX;
            busy_s  = 1'b1;
            count_d = load_s;
            state_d = (load_s == {CNT_W{1'b0}}) ? ST_MC_DONE : ST_MC_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MC_RUN: begin
          busy_s = 1'b1;
          if (mc_cancel) begin
            state_d = ST_IDLE;
            count_d = {CNT_W{1'b0}};
          end else begin
            stall_s = STALL_EX;
            count_d = count_q - CNT_W'(1);
            state_d = (count_q <= CNT_W'(1)) ? ST_MC_DONE : ST_MC_RUN;
          end
        end
        ST_MC_DONE: begin
          done_s  = !mc_cancel;
          state_d = ST_IDLE;
          count_d = {CNT_W{1'b0}};
        end
        default: begin
          state_d = ST_IDLE;
          count_d = {CNT_W{1'b0}};
        end
      endcase
    end

    if (stall_s[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // FSM, op counter and stall-cycle counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= {CNT_W{1'b0}};
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are held quiet while reset is low, even with requests pending.
  always_comb begin
    if (rst) begin
      stall   = STALL_W'(stall_s);
      flush   = flush_s;
      mc_busy = busy_s;
      mc_done = done_s;
    end else begin
      stall   = {STALL_W{1'b0}};
      flush   = 1'b0;
      mc_busy = 1'b0;
      mc_done = 1'b0;
    end
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 6, width of multi-cycle length and count.
REQ-002 SHALL have parameter STALL_W, default 6, stall vector width {wb,mem,ex,id,if,pc}, bit0=pc.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stallreq_id  input  1  decode-stage hazard stall request.
REQ-006 SHALL have port stallreq_ex  input  1  execute-stage single-cycle stall request.
REQ-007 SHALL have port mc_start  input  1  execute stage begins multi-cycle op (div/madd).
REQ-008 SHALL have port mc_cycles  input  CNT_W  length N of that op, sampled with mc_start.
REQ-009 SHALL have port mc_cancel  input  1  abort in-flight multi-cycle op.
REQ-010 SHALL have port flush_req  input  1  pipeline flush request.
REQ-011 SHALL have port stall  output  STALL_W  per-stage hold enables.
REQ-012 SHALL have port flush  output  1  clear all pipeline registers (EX/MEM included).
REQ-013 SHALL have port mc_busy  output  1  multi-cycle op in progress.
REQ-014 SHALL have port mc_done  output  1  one-cycle pulse: result valid, EX/MEM may latch wreg/whilo.
REQ-015 SHALL have port stall_cnt  output  32  saturating count of cycles with stall[0]=1.

Function
REQ-016 SHALL implement states IDLE, MC_RUN, MC_DONE; encoding free.
REQ-017 SHALL, in IDLE with mc_start=1, load count with Neff-1, where Neff = mc_cycles, or 1 when mc_cycles=0.
REQ-018 SHALL go IDLE->MC_DONE if Neff=1, else IDLE->MC_RUN.
REQ-019 SHALL, in MC_RUN, decrement count each cycle and go to MC_DONE on the cycle count==1.
REQ-020 SHALL go MC_DONE->IDLE unconditionally after one cycle.
REQ-021 SHALL assert stall=6'b001111 on the mc_start cycle and in every MC_RUN cycle, so the stall lasts exactly Neff cycles.
REQ-022 SHALL assert mc_done=1 and mc_busy=0 only in MC_DONE.
REQ-023 SHALL assert mc_busy=1 on the mc_start cycle (IDLE) and throughout MC_RUN.
REQ-024 SHALL ignore mc_start outside IDLE.
REQ-025 SHALL, outside multi-cycle stalls, drive stall=6'b001111 if stallreq_ex, else 6'b000111 if stallreq_id, else 0; stall is combinational.
REQ-026 SHALL, in MC_RUN with stallreq_id or stallreq_ex also high, keep stall=6'b001111.
REQ-027 SHALL, on mc_cancel in MC_RUN or MC_DONE, return to IDLE next cycle, force mc_done=0 that cycle, and keep stall as per REQ-025.
REQ-028 SHALL, on flush_req, drive flush=1 and stall=0 the same cycle, force mc_done=0, and go to IDLE next cycle.
REQ-029 SHALL give flush_req priority over mc_cancel, and mc_cancel priority over mc_start.
REQ-030 SHALL increment stall_cnt each cycle stall[0]=1, saturating at 32'hFFFFFFFF.

Reset
REQ-031 SHALL, while rst=0, asynchronously force state=IDLE, count=0, stall_cnt=0.
REQ-032 SHALL, while rst=0, hold outputs at stall=0, flush=0, mc_busy=0, mc_done=0.
REQ-033 SHALL, on reset assertion mid-operation, abort the op with no mc_done pulse.

Structure
REQ-034 SHALL take state encodings and the stall patterns 6'b000111 and 6'b001111 from the shared defines file.
REQ-035 SHALL put the FSM and counter in a single module, with no sub-module.

Verification
REQ-036 SHALL cover: mc_start, mc_cycles=4 -> stall=6'b001111 for cycles 0..3, mc_done=1 at cycle 4, stall=0 at cycle 4.
REQ-037 SHALL cover: mc_cycles=0 and mc_cycles=1 -> stall for 1 cycle, mc_done at cycle 1.
REQ-038 SHALL cover: stallreq_id=1 alone -> stall=6'b000111; stallreq_id and stallreq_ex both 1 -> stall=6'b001111.
REQ-039 SHALL cover: mc_cycles=8, flush_req at cycle 3 -> flush=1, stall=0 at cycle 3, IDLE at cycle 4, no mc_done.
REQ-040 SHALL cover: mc_cycles=5, rst low at cycle 2 -> all outputs 0 immediately, no mc_done after release, stall_cnt=0.
REQ-041 SHALL cover: stall_cnt preloaded by force to 32'hFFFFFFFE, 3 stall cycles -> stall_cnt=32'hFFFFFFFF.
